// File: rtl/rv32i_types.sv
// Shared RV32 types: multiplier op encoding, FU state, and the CDB/RVFI bundles.
package rv32i_types;

    localparam int PHYS_REG_W = 6;
    localparam int ROB_IDX_W  = 4;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } mul_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
    } rvfi_data_t;

    typedef struct packed {
        logic [PHYS_REG_W-1:0] pd_s;
        logic [ROB_IDX_W-1:0]  rob_num;
        logic [31:0]           pd_v;
        logic [31:0]           instr_pc;
        logic                  br_en;
        logic                  instr_is_br;
        logic                  br_taken;
        logic [31:0]           br_target;
        rvfi_data_t            rvfi_data;
    } fu_cdb_data_t;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mul_fu_if.sv
// Issue and CDB-side signals of the multiplier FU; slave is the FU itself.
interface mul_fu_if;
    import rv32i_types::*;

    logic                  issue_valid;
    logic                  issue_ready;
    mul_op_t               mul_op;
    logic [31:0]           rs1_v;
    logic [31:0]           rs2_v;
    logic [PHYS_REG_W-1:0] pd_s;
    logic [ROB_IDX_W-1:0]  rob_num;
    logic [31:0]           instr_pc;
    rvfi_data_t            rvfi_in;
    logic                  fu_done;
    fu_cdb_data_t          fu_data;
    logic                  ack;

    modport slave (
        input  issue_valid, mul_op, rs1_v, rs2_v, pd_s, rob_num, instr_pc, rvfi_in, ack,
        output issue_ready, fu_done, fu_data
    );

    modport master (
        output issue_valid, mul_op, rs1_v, rs2_v, pd_s, rob_num, instr_pc, rvfi_in, ack,
        input  issue_ready, fu_done, fu_data
    );
endinterface

// File: rtl/mul_fu_datapath.sv
// Shift-add core: operand magnitudes, accumulator and shift registers, final sign fix and half select.
module mul_datapath
    import rv32i_types::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_step,
    input  mul_op_t     i_op,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic [31:0] o_result
);
    logic        w_sign1, w_sign2;
    logic [63:0] r_mcand, r_acc;
    logic [31:0] r_mplier;
    logic        r_neg;
    mul_op_t     r_op;
    logic [63:0] w_pp, w_acc_next, w_prod;

    always_comb begin
        w_sign1 = i_rs1[31] & (i_op != MULHU);
        w_sign2 = i_rs2[31] & ((i_op == MUL) || (i_op == MULH));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_op     <= MUL;
        end else if (i_load) begin
            r_mcand  <= {32'd0, mag32(i_rs1, w_sign1)};
            r_mplier <= mag32(i_rs2, w_sign2);
            r_acc    <= '0;
            r_neg    <= w_sign1 ^ w_sign2;
            r_op     <= i_op;
        end else if (i_step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
        end
    end

    // The product is formed from this cycle's accumulator so the FU can register it on the last step.
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_mplier[j]) w_pp = w_pp + (r_mcand << j);
        end
        w_acc_next = r_acc + w_pp;
        w_prod     = r_neg ? (64'd0 - w_acc_next) : w_acc_next;
        o_result   = (r_op == MUL) ? w_prod[31:0] : w_prod[63:32];
    end
endmodule

// File: rtl/mul_fu.sv
// RV32M multiplier FU: issue handshake, CALC sequencing, result hold until CDB ack.
//   state  | meaning
//   S_IDLE | ready for an op
//   S_CALC | retiring multiplier bits
//   S_DONE | result presented, waiting for ack
module mul_fu
    import rv32i_types::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input logic      i_clk,
    input logic      i_rst,
    input logic      i_flush,
    mul_fu_if.slave  io_fu
);
    localparam int N  = 32 / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    mul_state_t   r_state, w_state_next;
    logic [CW-1:0] r_count;
    fu_cdb_data_t r_fu_data;
    logic         w_accept, w_last;
    logic [31:0]  w_result;

    assign io_fu.issue_ready = (r_state == S_IDLE) & ~i_rst;
    assign io_fu.fu_done     = (r_state == S_DONE);
    assign io_fu.fu_data     = r_fu_data;

    assign w_accept = io_fu.issue_valid & io_fu.issue_ready & ~i_flush;
    assign w_last   = (r_state == S_CALC) & (r_count == CW'(N - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_CALC;
            S_CALC:  if (w_last) w_state_next = S_DONE;
            S_DONE:  if (io_fu.ack) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (i_flush) w_state_next = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) r_count <= '0;
            else if (r_state == S_CALC) r_count <= r_count + 1'b1;
        end
    end

    // Branch fields are only ever cleared by reset, so they stay zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fu_data <= '0;
        end else begin
            if (w_accept) begin
                r_fu_data.pd_s      <= io_fu.pd_s;
                r_fu_data.rob_num   <= io_fu.rob_num;
                r_fu_data.instr_pc  <= io_fu.instr_pc;
                r_fu_data.rvfi_data <= io_fu.rvfi_in;
            end
            if (w_last && !i_flush) begin
                r_fu_data.pd_v               <= w_result;
                r_fu_data.rvfi_data.rd_wdata <= w_result;
            end
        end
    end

    mul_datapath #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_dp (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_accept),
        .i_step   (r_state == S_CALC),
        .i_op     (io_fu.mul_op),
        .i_rs1    (io_fu.rs1_v),
        .i_rs2    (io_fu.rs2_v),
        .o_result (w_result)
    );
endmodule

// File: tb/tb_mul_fu.sv
// Directed bench for mul_fu: latency, signed/unsigned results, back-pressure, flush and reset.
module tb_mul_fu;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst, flush;
    int   n_checks = 0;
    int   n_fail   = 0;

    mul_fu_if u_if();

    mul_fu #(.BITS_PER_CYCLE(2)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .io_fu   (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input mul_op_t op, input logic [31:0] a, input logic [31:0] b,
                            input logic [PHYS_REG_W-1:0] pd, input logic [ROB_IDX_W-1:0] rob);
        u_if.issue_valid       = 1'b1;
        u_if.mul_op            = op;
        u_if.rs1_v             = a;
        u_if.rs2_v             = b;
        u_if.pd_s              = pd;
        u_if.rob_num           = rob;
        u_if.instr_pc          = 32'h0000_1000;
        u_if.rvfi_in           = '0;
        u_if.rvfi_in.valid     = 1'b1;
        u_if.rvfi_in.pc_rdata  = 32'h0000_1000;
        u_if.rvfi_in.rd_wdata  = 32'hDEAD_BEEF;
    endtask

    task automatic issue(input mul_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [PHYS_REG_W-1:0] pd = 1, input logic [ROB_IDX_W-1:0] rob = 0);
        @(negedge clk);
        drive_op(op, a, b, pd, rob);
        @(posedge clk);
        #1 u_if.issue_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1 cyc++;
        end while (!u_if.fu_done && cyc < 40);
    endtask

    task automatic ack_it();
        @(negedge clk);
        u_if.ack = 1'b1;
        @(posedge clk);
        #1 u_if.ack = 1'b0;
    endtask

    task automatic run_op(input string tag, input mul_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int c;
        issue(op, a, b);
        wait_done(c);
        check_val({tag, "_lat"}, c, 16);
        check_val({tag, "_pdv"}, u_if.fu_data.pd_v, exp);
        ack_it();
        check_val({tag, "_done_low"}, u_if.fu_done, 0);
    endtask

    initial begin
        int  c;
        logic seen, ok;
        rst = 1'b1;
        flush = 1'b0;
        u_if.issue_valid = 1'b0;
        u_if.ack = 1'b0;
        drive_op(MUL, 0, 0, 0, 0);
        u_if.issue_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_done", u_if.fu_done, 0);
        check_val("rst_ready", u_if.issue_ready, 0);
        check_val("rst_pdv", u_if.fu_data.pd_v, 0);
        @(negedge clk) rst = 1'b0;
        #1 check_val("post_rst_ready", u_if.issue_ready, 1);

        // MUL 7*6 with metadata checks
        issue(MUL, 32'd7, 32'd6, 6'd5, 4'd3);
        wait_done(c);
        check_val("mul76_lat", c, 16);
        check_val("mul76_pdv", u_if.fu_data.pd_v, 42);
        check_val("mul76_pds", u_if.fu_data.pd_s, 5);
        check_val("mul76_rob", u_if.fu_data.rob_num, 3);
        check_val("mul76_pc", u_if.fu_data.instr_pc, 32'h0000_1000);
        check_val("mul76_br_en", u_if.fu_data.br_en, 0);
        check_val("mul76_br_tgt", u_if.fu_data.br_target, 0);
        check_val("mul76_rvfi_wd", u_if.fu_data.rvfi_data.rd_wdata, 42);
        check_val("mul76_rvfi_pc", u_if.fu_data.rvfi_data.pc_rdata, 32'h0000_1000);
        ack_it();
        check_val("mul76_ack_done", u_if.fu_done, 0);
        check_val("mul76_ack_ready", u_if.issue_ready, 1);

        run_op("mul_m1m1", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("mulh_m1m1", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulh_min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhsu_ff", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu_ff", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mul_zero", MUL, 32'd0, 32'h8000_0000, 32'd0);
        run_op("mulh_neg", MULH, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF);

        // Back-pressure: hold ack low while the next op waits at the issue port
        issue(MUL, 32'hFFFF_FFF9, 32'd6);
        wait_done(c);
        check_val("bp_lat", c, 16);
        @(negedge clk);
        drive_op(MUL, 32'd3, 32'd5, 6'd2, 4'd1);
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (!(u_if.fu_done === 1'b1 && u_if.fu_data.pd_v === 32'hFFFF_FFD6 &&
                  u_if.issue_ready === 1'b0)) ok = 1'b0;
        end
        check_val("bp_hold", ok, 1);
        ack_it();
        check_val("bp_ack_done", u_if.fu_done, 0);
        check_val("bp_ack_ready", u_if.issue_ready, 1);
        @(posedge clk);
        #1 u_if.issue_valid = 1'b0;
        check_val("bp_next_accepted", u_if.issue_ready, 0);
        wait_done(c);
        check_val("bp_next_lat", c, 16);
        check_val("bp_next_pdv", u_if.fu_data.pd_v, 15);
        ack_it();

        // Flush partway through CALC
        issue(MUL, 32'd5, 32'd5);
        repeat (4) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check_val("flush_ready", u_if.issue_ready, 1);
        check_val("flush_done", u_if.fu_done, 0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1 if (u_if.fu_done) seen = 1'b1;
        end
        check_val("flush_no_done", seen, 0);
        run_op("post_flush_mul33", MUL, 32'd3, 32'd3, 32'd9);

        // Flush coincident with issue in IDLE
        @(negedge clk);
        drive_op(MUL, 32'd4, 32'd4, 6'd1, 4'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        u_if.issue_valid = 1'b0;
        flush = 1'b0;
        check_val("flush_issue_not_acc", u_if.issue_ready, 1);

        // Reset while waiting for ack
        issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(c);
        check_val("rstd_lat", c, 16);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        check_val("rstd_done", u_if.fu_done, 0);
        check_val("rstd_ready", u_if.issue_ready, 1);
        check_val("rstd_pdv", u_if.fu_data.pd_v, 0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1 if (u_if.fu_done) seen = 1'b1;
        end
        check_val("rstd_no_stale", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
